// File: rtl/pipe_reg.sv
// Elastic pipeline register: WIDTH-bit data, DEPTH stages, valid/ready handshake
// with a global stall enable, synchronous flush and an occupancy count.
module pipe_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH+1);

    logic             v_reg [DEPTH];
    logic [WIDTH-1:0] d_reg [DEPTH];
    logic             r     [DEPTH];
    logic             src_v [DEPTH];
    logic [WIDTH-1:0] src_d [DEPTH];
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             move;
    logic             accept;
    logic             emit;

    assign move = enable && !flush;

    // Ready ripples back from the consumer; an empty stage is always ready.
    assign r[DEPTH-1] = !v_reg[DEPTH-1] || out_ready;
    assign src_v[0]   = in_valid;
    assign src_d[0]   = in_data;

    generate
        for (genvar gi = 0; gi < DEPTH-1; gi++) begin : g_chain
            assign r[gi]       = !v_reg[gi] || r[gi+1];
            assign src_v[gi+1] = v_reg[gi];
            assign src_d[gi+1] = d_reg[gi];
        end

        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             v_next;
            logic [WIDTH-1:0] d_next;

            always_comb begin
                v_next = v_reg[gi];
                d_next = d_reg[gi];
                if (flush) begin
                    v_next = 1'b0;
                    d_next = '0;
                end else if (move && r[gi]) begin
                    v_next = src_v[gi];
                    // Bubbles leave the data register untouched.
                    if (src_v[gi]) begin
                        d_next = src_d[gi];
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_reg[gi] <= 1'b0;
                    d_reg[gi] <= '0;
                end else begin
                    v_reg[gi] <= v_next;
                    d_reg[gi] <= d_next;
                end
            end
        end
    endgenerate

    assign in_ready  = move && !rst && r[0];
    assign out_valid = move && v_reg[DEPTH-1];
    assign out_data  = d_reg[DEPTH-1];
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else if (accept && !emit) begin
            count_next = count_reg + CW'(1);
        end else if (emit && !accept) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: tb/tb_pipe_reg.sv
// Bench for pipe_reg: four configurations share one stimulus stream; each is
// checked every cycle against a queue-of-beats position model, plus literal checks.
module tb_pipe_reg;
    logic        clk;
    logic        rst;
    logic        enable;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        in_ready_a  [4];
    logic        out_valid_a [4];
    logic [15:0] out_data_a  [4];
    logic [31:0] count_a     [4];

    int vectors     = 0;
    int miscompares = 0;
    int step_no     = 0;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [15:0] s_out_data;
    logic [31:0] s_count;
    logic [15:0] got_q [$];
    int          cyc_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
            localparam int D  = (gi == 0) ? 2 : (gi == 1) ? 1 : (gi == 2) ? 3 : 4;
            localparam int W  = (gi == 0) ? 8 : 16;
            localparam int CW = $clog2(D+1);

            logic          ir;
            logic          ov;
            logic [W-1:0]  od;
            logic [CW-1:0] cnt;

            // Model: beats oldest-first, each with its stage position.
            int           pos_q [$];
            logic [W-1:0] dat_q [$];
            logic [W-1:0] last_data = '0;
            int           ahead;
            logic         acc;

            pipe_reg #(.WIDTH(W), .DEPTH(D)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .enable    (enable),
                .flush     (flush),
                .in_valid  (in_valid),
                .in_data   (in_data[W-1:0]),
                .in_ready  (ir),
                .out_valid (ov),
                .out_data  (od),
                .out_ready (out_ready),
                .count     (cnt)
            );

            assign in_ready_a[gi]  = ir;
            assign out_valid_a[gi] = ov;
            assign out_data_a[gi]  = 16'(od);
            assign count_a[gi]     = 32'(cnt);

            initial forever begin
                @(posedge clk or posedge rst);
                if (rst || flush) begin
                    pos_q.delete();
                    dat_q.delete();
                    last_data = '0;
                end else if (enable) begin
                    acc = in_valid && (pos_q.size() < D || out_ready);
                    if (pos_q.size() > 0 && pos_q[0] == D-1 && out_ready) begin
                        void'(pos_q.pop_front());
                        void'(dat_q.pop_front());
                    end
                    ahead = D;
                    for (int i = 0; i < pos_q.size(); i++) begin
                        if (pos_q[i] + 1 < ahead) begin
                            pos_q[i] = pos_q[i] + 1;
                            if (pos_q[i] == D-1) last_data = dat_q[i];
                        end
                        ahead = pos_q[i];
                    end
                    if (acc) begin
                        pos_q.push_back(0);
                        dat_q.push_back(in_data[W-1:0]);
                        if (D == 1) last_data = in_data[W-1:0];
                    end
                end
            end

            initial forever begin
                @(negedge clk);
                chk($sformatf("d%0d_in_ready", D), 32'(ir),
                    32'(enable && !flush && !rst && (pos_q.size() < D || out_ready)));
                chk($sformatf("d%0d_out_valid", D), 32'(ov),
                    32'(enable && !flush && pos_q.size() > 0 && pos_q[0] == D-1));
                chk($sformatf("d%0d_out_data", D), 32'(od), 32'(last_data));
                chk($sformatf("d%0d_count", D), 32'(cnt), 32'(pos_q.size()));
            end
        end
    endgenerate

    // One cycle: drive inputs, snapshot instance 0 at the falling edge, then cross the edge.
    task automatic step(input logic iv, input logic [15:0] id, input logic ordy,
                        input logic en, input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        enable    = en;
        flush     = fl;
        @(negedge clk);
        s_in_ready  = in_ready_a[0];
        s_out_valid = out_valid_a[0];
        s_out_data  = out_data_a[0];
        s_count     = count_a[0];
        if (out_valid_a[0] && ordy) begin
            got_q.push_back(out_data_a[0]);
            cyc_q.push_back(step_no);
        end
        @(posedge clk);
        #1;
        step_no++;
    endtask

    initial begin
        int base;
        rst = 1'b1; enable = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset and idle, then a mid-cycle reset with two beats held.
        #2;
        chk("t1_rst_out_valid", 32'(out_valid_a[0]), 0);
        chk("t1_rst_in_ready", 32'(in_ready_a[0]), 0);
        chk("t1_rst_count", count_a[0], 0);
        @(posedge clk); #1;
        rst = 1'b0; enable = 1'b1;
        #1;
        chk("t1_idle_in_ready", 32'(in_ready_a[0]), 1);
        step(1, 16'hC1, 0, 1, 0);
        step(1, 16'hC2, 0, 1, 0);
        chk("t1_held_count", count_a[0], 2);
        chk("t1_held_data", 32'(out_data_a[0]), 32'hC1);
        #1 rst = 1'b1;
        #1;
        chk("t1_pulse_out_valid", 32'(out_valid_a[0]), 0);
        chk("t1_pulse_count", count_a[0], 0);
        chk("t1_pulse_out_data", 32'(out_data_a[0]), 0);
        chk("t1_pulse_in_ready", 32'(in_ready_a[0]), 0);
        #1 rst = 1'b0;

        // Streaming 0x01..0x08 with out_ready held.
        got_q.delete(); cyc_q.delete();
        base = step_no;
        for (int c = 0; c < 12; c++) begin
            step(c < 8, 16'(c + 1), 1, 1, 0);
            if (c >= 3 && c <= 7) chk("t2_count", s_count, 2);
        end
        chk("t2_beats", got_q.size(), 8);
        for (int k = 0; k < 8; k++) begin
            chk("t2_data", 32'(got_q[k]), 32'(k + 1));
            chk("t2_cycle", 32'(cyc_q[k] - base), 32'(k + 2));
        end

        // Backpressure fill, then drain with accept and emit together.
        got_q.delete();
        step(1, 16'hA1, 0, 1, 0);
        step(1, 16'hA2, 0, 1, 0);
        step(1, 16'hA3, 0, 1, 0);
        chk("t3_full_in_ready", 32'(s_in_ready), 0);
        chk("t3_full_count", s_count, 2);
        step(1, 16'hA3, 1, 1, 0);
        chk("t3_both_in_ready", 32'(s_in_ready), 1);
        chk("t3_both_out_data", 32'(s_out_data), 32'hA1);
        chk("t3_both_count", s_count, 2);
        step(0, 16'h0, 1, 1, 0);
        step(0, 16'h0, 1, 1, 0);
        step(0, 16'h0, 1, 1, 0);
        chk("t3_beats", got_q.size(), 3);
        chk("t3_order0", 32'(got_q[0]), 32'hA1);
        chk("t3_order1", 32'(got_q[1]), 32'hA2);
        chk("t3_order2", 32'(got_q[2]), 32'hA3);

        // Enable stall.
        step(1, 16'h55, 0, 1, 0);
        step(1, 16'h66, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 16'h99, 1, 0, 0);
            chk("t4_stall_in_ready", 32'(s_in_ready), 0);
            chk("t4_stall_out_valid", 32'(s_out_valid), 0);
            chk("t4_stall_count", s_count, 2);
        end
        got_q.delete();
        step(0, 16'h0, 1, 1, 0);
        chk("t4_resume_data", 32'(s_out_data), 32'h55);
        step(0, 16'h0, 1, 1, 0);
        chk("t4_resume_beats", got_q.size(), 2);
        chk("t4_second_data", 32'(got_q[1]), 32'h66);

        // Flush with traffic, then latency of a fresh beat.
        step(1, 16'h11, 0, 1, 0);
        step(1, 16'h22, 0, 1, 0);
        got_q.delete();
        step(1, 16'h33, 1, 1, 1);
        chk("t5_flush_in_ready", 32'(s_in_ready), 0);
        chk("t5_flush_out_valid", 32'(s_out_valid), 0);
        step(1, 16'h77, 1, 1, 0);
        chk("t5_after_count", s_count, 0);
        chk("t5_after_out_valid", 32'(s_out_valid), 0);
        chk("t5_after_in_ready", 32'(s_in_ready), 1);
        step(0, 16'h0, 1, 1, 0);
        chk("t5_lat1_out_valid", 32'(s_out_valid), 0);
        step(0, 16'h0, 1, 1, 0);
        chk("t5_lat2_out_valid", 32'(s_out_valid), 1);
        chk("t5_lat2_out_data", 32'(s_out_data), 32'h77);
        chk("t5_no_stale", got_q.size(), 1);
        step(0, 16'h0, 1, 1, 0);

        // Random traffic across all configurations.
        for (int k = 0; k < 10000; k++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
